// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//
// Bundles every non-clock signal of the fetch controller: the instruction
// memory read port, the fetch enable, the execute-stage redirect and the
// valid/ready stream toward decode.
//
// Signals
//   imem_addr  : byte address to instruction memory (fetch side drives)
//   imem_instr : instruction word for imem_addr, same cycle (memory drives)
//   fetch_en   : 1 = new fetches allowed, 0 = pause (buffer still drains)
//   br_valid   : one-cycle redirect request from execute
//   br_target  : redirect byte address, used when br_valid = 1
//   out_valid  : head buffer entry valid toward decode
//   out_ready  : decode accepts the head entry this cycle
//   out_instr  : head entry instruction word (0 when out_valid = 0)
//   out_pc     : head entry byte address (0 when out_valid = 0)
//   out_pc8    : out_pc + 8, modulo 2^32 (0 when out_valid = 0)
//
// Modports
//   master : the fetch controller
//   slave  : the surrounding pipeline / memory / testbench
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        fetch_en;
    logic        br_valid;
    logic [31:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  fetch_en,
        input  br_valid,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc8
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output fetch_en,
        output br_valid,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc8
    );
endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch controller. Keeps a word-aligned fetch PC (fpc), reads the
// instruction memory combinationally at fpc, and captures {pc, instr} pairs
// into a 2-entry in-order buffer that feeds decode through a valid/ready
// handshake. A redirect from execute flushes the buffer and reloads fpc.
//
// Parameters
//   RESET_PC : fetch address after reset; bits [1:0] are forced to zero
//
// Ports
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous, active-high; overrides every other input
//   bus   : fetch_ctrl_if.master (memory port, redirect, decode stream)
//
// Behaviour summary
//   pop     = out_valid & out_ready (head removed at the edge)
//   capture = !br_valid & fetch_en & (count < 2 | pop)
//   redirect: count -> 0, fpc -> {br_target[31:2], 2'b00}, no capture.
//             A pop in the same cycle still counts as accepted by decode.
//   There is no bypass: an entry captured at edge N is visible at N+1.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] fpc_q,   fpc_d;
    logic [1:0]  count_q, count_d;    // occupancy 0..2
    logic        head_q,  head_d;     // slot index of the oldest entry

    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_pc_d    [2];
    logic [31:0] ent_instr_q [2];
    logic [31:0] ent_instr_d [2];

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic       head_valid;
    logic       pop;
    logic       capture;
    logic       tail;

    assign head_valid = (count_q != 2'd0);
    assign pop        = head_valid && bus.out_ready;
    // A full buffer may still capture when the head leaves in the same cycle.
    assign capture    = !bus.br_valid && bus.fetch_en &&
                        ((count_q != 2'd2) || pop);
    // With two slots the tail is head+count mod 2; at count=2 it aliases the
    // head slot, which is only written when that head is popping.
    assign tail       = head_q ^ count_q[0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned, which would infer a latch.
        fpc_d       = fpc_q;
        count_d     = count_q;
        head_d      = head_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;

        if (bus.br_valid) begin
            // Flush: a concurrent pop is already consumed by decode, the
            // remaining entries are simply discarded.
            count_d = 2'd0;
            head_d  = 1'b0;
            fpc_d   = {bus.br_target[31:2], 2'b00};
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end

            if (capture) begin
                ent_pc_d[tail]    = fpc_q;
                ent_instr_d[tail] = bus.imem_instr;
                // Natural 32-bit wrap FFFF_FFFC -> 0000_0000.
                fpc_d             = fpc_q + 32'd4;
            end

            unique case ({capture, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
        if (reset) begin
            fpc_q   <= RESET_PC_ALIGNED;
            count_q <= 2'd0;
            head_q  <= 1'b0;
        end else begin
            fpc_q   <= fpc_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer storage
    // -------------------------------------------------------------------------
    // NOTE: the payload slots are deliberately not reset; count_q qualifies them and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic [31:0] head_pc;
    logic [31:0] head_instr;

    assign head_pc    = ent_pc_q[head_q];
    assign head_instr = ent_instr_q[head_q];

    assign bus.imem_addr = fpc_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_valid ? head_pc               : 32'd0;
    assign bus.out_instr = head_valid ? head_instr            : 32'd0;
    assign bus.out_pc8   = head_valid ? (head_pc + 32'd8)     : 32'd0;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_count_range : assert property (@(posedge clk) disable iff (reset)
        count_q != 2'd3);
    a_fpc_aligned : assert property (@(posedge clk) disable iff (reset)
        fpc_q[1:0] == 2'b00);

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. The instruction memory returns word index
// (addr >> 2) so every expected pc/instr pair is computed by hand. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Memory: word i holds value i.
    assign bus.imem_instr = {2'b00, bus.imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {valid, pc, instr, pc8}
    function automatic logic [96:0] obs_head();
        return {bus.out_valid, bus.out_pc, bus.out_instr, bus.out_pc8};
    endfunction

    function automatic logic [96:0] exp_head(input logic v,
                                             input logic [31:0] pc,
                                             input logic [31:0] instr);
        return v ? {1'b1, pc, instr, pc + 32'd8} : 97'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.br_valid  = 1'b0;
        bus.fetch_en  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset with every other input active, including a redirect.
    task automatic test_reset();
        logic [96:0] e;
        reset         = 1'b1;
        bus.fetch_en  = 1'b1;
        bus.out_ready = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0000_0080;
        tick();
        tick();
        e = exp_head(1'b0, 32'd0, 32'd0);
        n_cmp++;
        if (obs_head() !== e) begin
            n_err++;
            $display("FAIL reset_head: got %h expected %h", obs_head(), e);
        end
        n_cmp++;
        if (bus.imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL reset_imem_addr: got %h expected %h", bus.imem_addr, 32'd0);
        end
        reset        = 1'b0;
        bus.br_valid = 1'b0;
    endtask

    // One instruction per cycle, first valid one cycle after release.
    task automatic test_stream();
        logic [96:0] e;
        // Cycle of release: nothing captured yet.
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_release_valid: got %b expected 0", bus.out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            e = exp_head(1'b1, 32'(4 * i), 32'(i));
            n_cmp++;
            if (obs_head() !== e) begin
                n_err++;
                $display("FAIL stream_head[%0d]: got %h expected %h", i, obs_head(), e);
            end
            n_cmp++;
            if (bus.imem_addr !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL stream_imem[%0d]: got %h expected %h", i, bus.imem_addr, 32'(4 * i + 4));
            end
        end
    endtask

    // Decode stalls for 5 cycles; buffer saturates, then drains in order.
    task automatic test_backpressure();
        logic [96:0] e;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        e = exp_head(1'b1, 32'd0, 32'd0);
        n_cmp++;
        if (obs_head() !== e) begin
            n_err++;
            $display("FAIL bp_full_head: got %h expected %h", obs_head(), e);
        end
        n_cmp++;
        if (bus.imem_addr !== 32'd8) begin
            n_err++;
            $display("FAIL bp_full_imem: got %h expected %h", bus.imem_addr, 32'd8);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            e = exp_head(1'b1, 32'(4 * i), 32'(i));
            n_cmp++;
            if (obs_head() !== e) begin
                n_err++;
                $display("FAIL bp_drain_head[%0d]: got %h expected %h", i, obs_head(), e);
            end
            n_cmp++;
            if (bus.imem_addr !== 32'(4 * i + 8)) begin
                n_err++;
                $display("FAIL bp_drain_imem[%0d]: got %h expected %h", i, bus.imem_addr, 32'(4 * i + 8));
            end
        end
    endtask

    // Redirect while full with a concurrent pop; target low bits dropped.
    task automatic test_redirect();
        logic [96:0] e;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.out_ready = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0000_0043;
        tick();
        bus.br_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_flush_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.imem_addr !== 32'h0000_0040) begin
            n_err++;
            $display("FAIL redir_imem: got %h expected %h", bus.imem_addr, 32'h40);
        end
        tick();
        e = exp_head(1'b1, 32'h0000_0040, 32'h0000_0010);
        n_cmp++;
        if (obs_head() !== e) begin
            n_err++;
            $display("FAIL redir_target_head: got %h expected %h", obs_head(), e);
        end
    endtask

    // fetch_en=0 drains the buffer while fpc holds, then fetch resumes.
    task automatic test_fetch_pause();
        logic [96:0] e;
        logic [96:0] exp_seq [5];
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.fetch_en  = 1'b0;
        bus.out_ready = 1'b1;
        exp_seq[0] = exp_head(1'b1, 32'd4,  32'd1);
        exp_seq[1] = exp_head(1'b0, 32'd0,  32'd0);
        exp_seq[2] = exp_head(1'b0, 32'd0,  32'd0);
        exp_seq[3] = exp_head(1'b1, 32'd8,  32'd2);
        exp_seq[4] = exp_head(1'b1, 32'd12, 32'd3);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) bus.fetch_en = 1'b1;
            tick();
            e = exp_seq[i];
            n_cmp++;
            if (obs_head() !== e) begin
                n_err++;
                $display("FAIL pause_head[%0d]: got %h expected %h", i, obs_head(), e);
            end
            if (i < 3) begin
                n_cmp++;
                if (bus.imem_addr !== 32'd8) begin
                    n_err++;
                    $display("FAIL pause_imem[%0d]: got %h expected %h", i, bus.imem_addr, 32'd8);
                end
            end
        end
    endtask

    // fpc wraps at the top of the address space; out_pc8 wraps too.
    task automatic test_wrap();
        logic [96:0] e;
        logic [31:0] pcs [3];
        pcs[0] = 32'hFFFF_FFF8;
        pcs[1] = 32'hFFFF_FFFC;
        pcs[2] = 32'h0000_0000;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'hFFFF_FFF8;
        tick();
        bus.br_valid = 1'b0;
        n_cmp++;
        if (bus.imem_addr !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL wrap_imem: got %h expected %h", bus.imem_addr, 32'hFFFF_FFF8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_head(1'b1, pcs[i], {2'b00, pcs[i][31:2]});
            n_cmp++;
            if (obs_head() !== e) begin
                n_err++;
                $display("FAIL wrap_head[%0d]: got %h expected %h", i, obs_head(), e);
            end
        end
        n_cmp++;
        if (bus.imem_addr !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL wrap_imem_after: got %h expected %h", bus.imem_addr, 32'h4);
        end
    endtask

    // Reset wins over a simultaneous redirect while the buffer is full.
    task automatic test_reset_vs_redirect();
        logic [96:0] e;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset         = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0000_0080;
        bus.out_ready = 1'b1;
        tick();
        reset        = 1'b0;
        bus.br_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rvr_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL rvr_imem: got %h expected %h", bus.imem_addr, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_head(1'b1, 32'(4 * i), 32'(i));
            n_cmp++;
            if (obs_head() !== e) begin
                n_err++;
                $display("FAIL rvr_restart_head[%0d]: got %h expected %h", i, obs_head(), e);
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.fetch_en  = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_target = 32'd0;
        bus.out_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fetch_pause();
        test_wrap();
        test_reset_vs_redirect();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset; bits [1:0] SHALL be treated as 0.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_addr  output  32  byte address driven to the instruction memory (combinational word read; bits [1:0] ignored by memory).
REQ-005 imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 fetch_en  input  1  1 = new fetches permitted; 0 = fetching paused, buffer still drains.
REQ-007 br_valid  input  1  one-cycle redirect request from execute (branch taken / PC write).
REQ-008 br_target  input  32  redirect byte address, sampled when br_valid=1.
REQ-009 out_valid  output  1  head buffer entry valid toward decode.
REQ-010 out_ready  input  1  decode accepts head entry this cycle.
REQ-011 out_instr  output  32  instruction word of head entry.
REQ-012 out_pc  output  32  byte address of head entry.
REQ-013 out_pc8  output  32  out_pc + 8 (architectural PC-read value), modulo 2^32.

Function
REQ-014 Internal fetch PC register fpc SHALL hold a word-aligned byte address; imem_addr SHALL equal fpc combinationally.
REQ-015 Block SHALL contain a 2-entry in-order buffer of {pc, instr} pairs with occupancy count 0..2.
REQ-016 Pop: out_valid=1 and out_ready=1 in a cycle SHALL remove the head entry at that edge.
REQ-017 Capture: when br_valid=0, fetch_en=1, and (count<2 or pop this cycle), {fpc, imem_instr} SHALL be written to the buffer tail and fpc SHALL advance by 4 at that edge.
REQ-018 Simultaneous capture and pop at count=2 SHALL leave count=2; at count=1 SHALL leave count=1; at count=0 the new entry SHALL become head next cycle (no bypass, out_valid=0 during the capture cycle).
REQ-019 No capture SHALL occur when the buffer is full and no pop occurs; fpc SHALL hold.
REQ-020 fetch_en=0 SHALL suppress capture and hold fpc; pops SHALL continue normally.
REQ-021 Redirect: br_valid=1 SHALL, at that edge, discard all buffer entries (count=0), load fpc with {br_target[31:2],2'b00}, and perform no capture regardless of fetch_en.
REQ-022 A pop handshake in the same cycle as br_valid=1 SHALL count as completed by decode; the flush discards only the remaining entries.
REQ-023 fpc increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error indication.
REQ-024 out_valid SHALL equal (count!=0); out_instr, out_pc, out_pc8 SHALL reflect the head entry when out_valid=1 and SHALL be 0 when out_valid=0.
REQ-025 Latency: an instruction captured at edge N SHALL be presented with out_valid=1 in cycle N+1 if it is head; sustained throughput with out_ready=1 and fetch_en=1 SHALL be one instruction per cycle.
REQ-026 Entries SHALL be presented in strictly increasing fetch order between redirects; no entry SHALL be duplicated or skipped.

Reset
REQ-027 reset=1 at an edge SHALL set fpc=RESET_PC (low bits cleared), count=0, buffer pointers to 0; all other inputs SHALL be ignored that cycle, including br_valid and out_ready.
REQ-028 During and after reset until first capture: out_valid=0, out_instr=0, out_pc=0, out_pc8=0; imem_addr=RESET_PC.
REQ-029 Reset asserted mid-stream SHALL drop all buffered entries; fetching SHALL restart at RESET_PC on the first edge with reset=0.

Verification
REQ-030 Reset release, RESET_PC=0, fetch_en=1, out_ready=1, memory word i = i -> out_valid rises one cycle after release; out_pc sequence 0,4,8,... with out_instr 0,1,2,... one per cycle, out_pc8 = out_pc+8.
REQ-031 out_ready=0 for 5 cycles from reset release -> count saturates at 2, fpc holds at 8, imem_addr=8; out_ready=1 then -> entries pc 0,4,8,12 delivered in order, none lost.
REQ-032 br_valid=1, br_target=32'h0000_0043 while count=2 and out_ready=1 -> head pc accepted, other entry discarded, next cycle out_valid=0, imem_addr=32'h40; following cycle out_pc=32'h40.
REQ-033 fetch_en=0 with count=2, out_ready=1 for 3 cycles -> two entries drain, out_valid=0 third cycle, fpc unchanged; fetch_en=1 resumes at the held fpc.
REQ-034 Redirect to 32'hFFFF_FFF8, run 3 fetches -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc8 for FFFF_FFFC = 32'h0000_0004.
REQ-035 reset=1 asserted together with br_valid=1 while count=2 -> redirect ignored, count=0, out_valid=0 next cycle, fetching restarts at RESET_PC.
